keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad (Digilent Pmod KYPD layout) and returns debounced hex key codes. It is the input-side counterpart of the seven-segment refresh path: it drives columns active-low in rotation and reads rows back, where the display path drives digits out. Accepted nibbles are packed into a 16-bit word that feeds the AES key/plaintext load registers.

---
 rtl/keypad_scanner.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: rotates an active-low column drive across a 4x4 keypad, classifies
// each full scan, debounces by whole-scan agreement and packs accepted hex codes.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clkin,
  input  logic        keypad_reset_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] word_out,
  output logic        word_ready
);

  localparam int               CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_THR    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } scan_res_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    if (v[3]) idx = 2'd3;
    return idx;
  endfunction

  // Pmod KYPD legend, indexed by {row, column}.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       row_p0, row_p1;
  logic [CNT_W-1:0] dwell_cnt;
  logic [1:0]       col_idx;
  logic             tick, scan_end;

  logic [3:0]       rows_low;
  logic             one_row;
  scan_res_t        acc_kind, acc_kind_nx;
  logic [3:0]       acc_code, acc_code_nx;

  scan_res_t        cand_kind, cand_kind_nx;
  logic [3:0]       cand_code, cand_code_nx;
  logic [3:0]       agree_cnt, agree_nx;
  logic             same_res;

  state_t           state, state_nx;
  logic [3:0]       key_code_nx;
  logic             key_held_nx, key_valid_nx, word_ready_nx;
  logic [15:0]      word_nx;
  logic [1:0]       nib_cnt, nib_nx;

  // Stage p0/p1: two-flop synchronizer on the asynchronous rows
  always_ff @(posedge clkin) begin
    if (!keypad_reset_n) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row_in;
      row_p1 <= row_p0;
    end
  end

  // Column dwell timing
  assign tick     = (dwell_cnt == DWELL_LAST);
  assign scan_end = tick && (col_idx == 2'd3);

  always_ff @(posedge clkin) begin
    if (!keypad_reset_n) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
    end else if (tick) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  assign col_out = ~(4'b0001 << col_idx);

  // Fold the current column's rows into the running scan result.
  always_comb begin
    rows_low    = ~row_p1;
    one_row     = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'h1)) == 4'h0);
    acc_kind_nx = acc_kind;
    acc_code_nx = acc_code;
    if (rows_low == 4'h0) begin
      acc_kind_nx = acc_kind;
    end else if (one_row && (acc_kind == RES_NONE)) begin
      acc_kind_nx = RES_KEY;
      acc_code_nx = key_map(onehot_idx(rows_low), col_idx);
    end else begin
      acc_kind_nx = RES_MULTI;
      acc_code_nx = 4'h0;
    end
  end

  // Whole-scan agreement against the stored candidate
  always_comb begin
    same_res     = (acc_kind_nx == cand_kind) && (acc_code_nx == cand_code);
    cand_kind_nx = acc_kind_nx;
    cand_code_nx = acc_code_nx;
    agree_nx     = 4'd1;
    if (same_res) begin
      cand_kind_nx = cand_kind;
      cand_code_nx = cand_code;
      agree_nx     = sat_inc4(agree_cnt);
    end
  end

  always_ff @(posedge clkin) begin
    if (!keypad_reset_n) begin
      acc_kind  <= RES_NONE;
      acc_code  <= 4'h0;
      cand_kind <= RES_NONE;
      cand_code <= 4'h0;
      agree_cnt <= 4'h0;
    end else if (tick) begin
      if (scan_end) begin
        acc_kind  <= RES_NONE;
        acc_code  <= 4'h0;
        cand_kind <= cand_kind_nx;
        cand_code <= cand_code_nx;
        agree_cnt <= agree_nx;
      end else begin
        acc_kind  <= acc_kind_nx;
        acc_code  <= acc_code_nx;
      end
    end
  end

  // Press/release FSM; MULTI results can neither accept nor release.
  always_comb begin
    state_nx      = state;
    key_code_nx   = key_code;
    key_held_nx   = key_held;
    key_valid_nx  = 1'b0;
    word_nx       = word_out;
    nib_nx        = nib_cnt;
    word_ready_nx = 1'b0;
    if (scan_end) begin
      case (state)
        ST_IDLE: begin
          if ((cand_kind_nx == RES_KEY) && (agree_nx >= DEB_THR)) begin
            state_nx      = ST_PRESSED;
            key_code_nx   = cand_code_nx;
            key_held_nx   = 1'b1;
            key_valid_nx  = 1'b1;
            word_nx       = {word_out[11:0], cand_code_nx};
            nib_nx        = nib_cnt + 2'd1;
            word_ready_nx = (nib_cnt == 2'd3);
          end
        end
        ST_PRESSED: begin
          if ((cand_kind_nx == RES_NONE) && (agree_nx >= DEB_THR)) begin
            state_nx    = ST_IDLE;
            key_held_nx = 1'b0;
          end
        end
      endcase
    end
  end

  // Stage p2: registered outputs, all updated together after the scan-end tick
  always_ff @(posedge clkin) begin
    if (!keypad_reset_n) begin
      state      <= ST_IDLE;
      key_code   <= 4'h0;
      key_held   <= 1'b0;
      key_valid  <= 1'b0;
      word_out   <= 16'h0000;
      nib_cnt    <= 2'd0;
      word_ready <= 1'b0;
    end else begin
      state      <= state_nx;
      key_code   <= key_code_nx;
      key_held   <= key_held_nx;
      key_valid  <= key_valid_nx;
      word_out   <= word_nx;
      nib_cnt    <= nib_nx;
      word_ready <= word_ready_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from col_out and a
// scoreboard of expected accepts is checked on every key_valid pulse.
module tb_keypad_scanner;

  localparam int SD  = 8;
  localparam int DB  = 2;
  localparam int LAT = (DB + 1) * 4 * SD + 2;

  localparam logic [3:0] KMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  typedef struct {
    logic [3:0]  code;
    logic [15:0] word;
    logic        ready;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] word_out;
  logic        word_ready;

  logic [15:0] pressed;
  logic [15:0] model_word;
  logic [1:0]  model_nib;
  logic        prev_valid;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clkin(clk),
    .keypad_reset_n(rst_n),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .word_out(word_out),
    .word_ready(word_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A pressed key shorts its row to the column currently driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && pressed[KMAP[r][c]]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_accept(input logic [3:0] code);
    exp_t e;
    model_word = {model_word[11:0], code};
    e.code  = code;
    e.word  = model_word;
    e.ready = (model_nib == 2'd3);
    model_nib = model_nib + 2'd1;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    model_word = 16'h0000;
    model_nib  = 2'd0;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (key_valid !== 1'b1 && n < budget);
    checks++;
    assert (key_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s_valid_timeout observed=%0d cycles expected<=%0d", tag, n, budget);
    end
  endtask

  task automatic wait_held_low(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (key_held !== 1'b0 && n < budget);
    checks++;
    assert (key_held === 1'b0) else begin
      errors++;
      $error("FAIL %s_release_timeout observed=%0d cycles expected<=%0d", tag, n, budget);
    end
  endtask

  // Returns at the negedge of the first cycle of a new scan (column 0 just driven).
  task automatic align_scan();
    logic [3:0] prev;
    logic       ok;
    int         n;
    n    = 0;
    ok   = 1'b0;
    prev = col_out;
    do begin
      @(negedge clk);
      ok   = (prev == 4'b0111) && (col_out == 4'b1110);
      prev = col_out;
      n++;
    end while (!ok && n < 8 * SD);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL align_scan observed=%b expected=1110 after 0111", col_out);
    end
  endtask

  task automatic press_release(input logic [3:0] code);
    int n;
    expect_accept(code);
    pressed[code] = 1'b1;
    wait_valid("press", LAT, n);
    chk("held_on_accept", 16'(key_held), 16'h1);
    pressed[code] = 1'b0;
    wait_held_low("release", LAT, n);
    chk("code_after_release", 16'(key_code), 16'(code));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (key_valid) begin
        chk("valid_not_back_to_back", 16'(prev_valid), 16'h0);
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_valid observed=code %0h expected=no pulse", key_code);
        end
        if (sb.size() > 0) begin
          chk("sb_code", 16'(key_code), 16'(sb[0].code));
          chk("sb_word", word_out, sb[0].word);
          chk("sb_word_ready", 16'(word_ready), 16'(sb[0].ready));
          void'(sb.pop_front());
        end
      end else if (word_ready) begin
        chk("word_ready_without_valid", 16'(key_valid), 16'h1);
      end
      prev_valid <= key_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] exp_col;

    // Reset, then reset again mid-scan
    pressed = 16'h0000;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_col_out", 16'(col_out), 16'h000E);
    chk("rst_key_code", 16'(key_code), 16'h0);
    chk("rst_key_valid", 16'(key_valid), 16'h0);
    chk("rst_key_held", 16'(key_held), 16'h0);
    chk("rst_word_out", word_out, 16'h0000);
    chk("rst_word_ready", 16'(word_ready), 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      exp_col = ~(4'b0001 << (i % 4));
      chk("col_step", 16'(col_out), 16'(exp_col));
      repeat (SD) @(negedge clk);
    end

    // Single press of "5"
    expect_accept(4'h5);
    pressed[5] = 1'b1;
    wait_valid("press5", LAT, n);
    repeat (4 * SD) @(negedge clk);
    chk("p5_held", 16'(key_held), 16'h1);
    chk("p5_code", 16'(key_code), 16'h5);
    chk("p5_word", word_out, 16'h0005);
    pressed[5] = 1'b0;
    repeat (30) @(negedge clk);
    chk("p5_held_during_release_debounce", 16'(key_held), 16'h1);
    wait_held_low("release5", LAT, n);
    chk("p5_code_kept", 16'(key_code), 16'h5);

    // Bouncing "9", then held
    align_scan();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      pressed[9] = (i % 2 == 0);
      repeat (20) @(negedge clk);
    end
    expect_accept(4'h9);
    pressed[9] = 1'b1;
    wait_valid("bounce9", LAT, n);
    chk("b9_held", 16'(key_held), 16'h1);
    pressed[9] = 1'b0;
    wait_held_low("release9", LAT, n);

    // "1" and "D" together, then drop "D"
    pressed[1]  = 1'b1;
    pressed[13] = 1'b1;
    repeat (6 * 4 * SD) @(negedge clk);
    chk("multi_not_held", 16'(key_held), 16'h0);
    expect_accept(4'h1);
    pressed[13] = 1'b0;
    wait_valid("multi1", LAT, n);
    chk("multi_min_latency", 16'(n >= 4 * SD), 16'h1);
    chk("multi_code", 16'(key_code), 16'h1);
    pressed[1] = 1'b0;
    wait_held_low("release1", LAT, n);

    // Reset after one agreeing scan of "3"
    align_scan();
    pressed[3] = 1'b1;
    repeat (34) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("mid_rst_held", 16'(key_held), 16'h0);
    chk("mid_rst_word", word_out, 16'h0000);
    chk("mid_rst_col", 16'(col_out), 16'h000E);
    rst_n = 1'b1;
    expect_accept(4'h3);
    wait_valid("mid_rst3", LAT, n);
    chk("mid_rst_latency", 16'(n), 16'(2 * 4 * SD));
    pressed[3] = 1'b0;
    wait_held_low("release3", LAT, n);

    // Word packing from a clean nibble count
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("pack_rst_word", word_out, 16'h0000);
    chk("pack_rst_code", 16'(key_code), 16'h0);
    rst_n = 1'b1;
    press_release(4'hA);
    press_release(4'hE);
    press_release(4'h5);
    press_release(4'h1);
    chk("word_AE51", word_out, 16'hAE51);
    press_release(4'hF);
    chk("word_E51F", word_out, 16'hE51F);
    chk("word_ready_idle", 16'(word_ready), 16'h0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
